// File: rtl/perf_monitor_if.sv
// Bus between the pipeline observation points and perf_monitor.
// The master side (pipeline or testbench) drives the event strobes, the
// tohost store bus and the readout select. The slave side (perf_monitor)
// returns the registered readout and the status flags.
interface perf_monitor_if;
  logic        clr;
  logic        retire_valid;
  logic        stall;
  logic        flush;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        done;
  logic        pass;
  logic        timeout;

  modport master (
    output clr, retire_valid, stall, flush, mem_we, mem_addr, mem_wdata, rd_sel,
    input  rd_data, done, pass, timeout
  );

  modport slave (
    input  clr, retire_valid, stall, flush, mem_we, mem_addr, mem_wdata, rd_sel,
    output rd_data, done, pass, timeout
  );
endinterface

// File: rtl/perf_monitor.sv
// perf_monitor: cycle / retire / stall / flush counters for the pipeline,
// tohost end-of-test detection with result capture, a retirement watchdog
// and a single registered readout port.
// Optional build macro PERF_MON_CPI_EN adds a sequential restoring divider
// that computes CPI x 100 after the test ends (readout select 6).
module perf_monitor #(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] DONE_ADDR  = 32'd100,
  parameter logic [31:0] PASS_VALUE = 32'd25,
  parameter int          WD_LIMIT   = 256
) (
  input  logic           clk,
  input  logic           rst,
  perf_monitor_if.slave  bus
);

  localparam int IDLE_W = $clog2(WD_LIMIT) + 1;

  typedef enum logic [1:0] {RUN, DONE, TIMEOUT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   instret;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [31:0]        result;
  logic               done_q;
  logic               pass_q;
  logic               timeout_q;
  logic [31:0]        rd_mux;
  logic [31:0]        rd_data_q;

  logic               run;
  logic               store_hit;
  logic               wd_expire;
  logic [CNT_W-1:0]   cycle_nxt;
  logic [CNT_W-1:0]   instret_nxt;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
    if (en && (v != '1))
      return v + CNT_W'(1);
    return v;
  endfunction

  assign run         = (state == RUN);
  assign store_hit   = bus.mem_we && (bus.mem_addr == DONE_ADDR);
  assign wd_expire   = !bus.retire_valid && (idle_cnt == IDLE_W'(WD_LIMIT - 1));
  assign cycle_nxt   = sat_inc(cycle_cnt, 1'b1);
  assign instret_nxt = sat_inc(instret, bus.retire_valid);

  // FSM, event counters, watchdog and captured result; a done store beats watchdog expiry.
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      state     <= RUN;
      cycle_cnt <= '0;
      instret   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      idle_cnt  <= '0;
      result    <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (bus.retire_valid)
        idle_cnt <= '0;
      else if (run)
        idle_cnt <= idle_cnt + IDLE_W'(1);

      if (run) begin
        cycle_cnt <= cycle_nxt;
        instret   <= instret_nxt;
        stall_cnt <= sat_inc(stall_cnt, bus.stall);
        flush_cnt <= sat_inc(flush_cnt, bus.flush);
        if (store_hit) begin
          state  <= DONE;
          result <= bus.mem_wdata;
          done_q <= 1'b1;
          pass_q <= (bus.mem_wdata == PASS_VALUE);
        end else if (wd_expire) begin
          state     <= TIMEOUT;
          timeout_q <= 1'b1;
        end
      end
    end
  end

`ifdef PERF_MON_CPI_EN
  localparam int DW   = CNT_W + 7;
  localparam int DC_W = $clog2(DW + 1);

  // div_q holds the dividend shifting out of its top while quotient bits shift in at the bottom.
  logic [DW-1:0]    div_q;
  logic [CNT_W-1:0] div_rem;
  logic [CNT_W-1:0] div_den;
  logic [DC_W-1:0]  div_cnt;
  logic             div_busy;
  logic             div_ok;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W:0]   rem_diff;
  logic             step_bit;
  logic [CNT_W-1:0] step_rem;
  logic             unused_div;

  assign rem_sh     = {div_rem, div_q[DW-1]};
  assign rem_diff   = rem_sh - {1'b0, div_den};
  assign step_bit   = (rem_sh >= {1'b0, div_den});
  assign step_rem   = step_bit ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
  assign unused_div = rem_diff[CNT_W];

  // Restoring divider, one quotient bit per cycle, started with the final counts on entering DONE.
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      div_busy <= 1'b0;
      div_ok   <= 1'b0;
    end else if (run && store_hit) begin
      div_q    <= DW'(cycle_nxt) * DW'(100);
      div_rem  <= '0;
      div_den  <= instret_nxt;
      div_cnt  <= DC_W'(DW);
      div_busy <= (instret_nxt != '0);
      div_ok   <= 1'b0;
    end else if (div_busy) begin
      div_q   <= {div_q[DW-2:0], step_bit};
      div_rem <= step_rem;
      div_cnt <= div_cnt - DC_W'(1);
      if (div_cnt == DC_W'(1)) begin
        div_busy <= 1'b0;
        div_ok   <= 1'b1;
      end
    end
  end
`endif

  // Readout select over the pre-update state; counters are zero-extended or truncated to 32 bits.
  always_comb begin
    rd_mux = 32'h0;
    case (bus.rd_sel)
      3'd0: rd_mux = 32'(cycle_cnt);
      3'd1: rd_mux = 32'(instret);
      3'd2: rd_mux = 32'(stall_cnt);
      3'd3: rd_mux = 32'(flush_cnt);
      3'd4: rd_mux = result;
      3'd5: rd_mux = {29'b0, timeout_q, pass_q, done_q};
`ifdef PERF_MON_CPI_EN
      3'd6: rd_mux = div_ok ? 32'(div_q) : 32'hFFFF_FFFF;
`else
      3'd6: rd_mux = 32'h0;
`endif
      default: rd_mux = 32'h0;
    endcase
  end

  // Readout register: one cycle of latency, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst)
      rd_data_q <= '0;
    else
      rd_data_q <= rd_mux;
  end

  assign bus.rd_data = rd_data_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Testbench for perf_monitor: directed scenarios plus randomized traffic,
// every cycle compared against a count-based reference model.
`timescale 1ns/1ps
module tb_perf_monitor;

  localparam int CNT_W = 32;
  localparam int WD    = 256;
  localparam longint unsigned CMAX = (64'd1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  perf_monitor_if bus();

  perf_monitor #(
    .CNT_W(CNT_W), .DONE_ADDR(32'd100), .PASS_VALUE(32'd25), .WD_LIMIT(WD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain totals and flags.
  longint unsigned m_cyc, m_ins, m_stl, m_fls, m_cpi;
  int              m_idle, m_since;
  bit              m_done, m_pass, m_to;
  logic [31:0]     m_res, m_rd;
  logic [31:0]     rv;
  int              n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned sinc(input longint unsigned v, input bit en);
    return (en && v < CMAX) ? v + 1 : v;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] s);
    case (s)
      3'd0: return 32'(m_cyc);
      3'd1: return 32'(m_ins);
      3'd2: return 32'(m_stl);
      3'd3: return 32'(m_fls);
      3'd4: return m_res;
      3'd5: return {29'b0, m_to, m_pass, m_done};
`ifdef PERF_MON_CPI_EN
      3'd6: return (m_done && m_ins != 0 && m_since >= CNT_W + 7) ? 32'(m_cpi) : 32'hFFFF_FFFF;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    m_cyc = 0; m_ins = 0; m_stl = 0; m_fls = 0; m_idle = 0;
    m_done = 0; m_pass = 0; m_to = 0; m_res = 0; m_since = 0; m_cpi = 0;
  endtask

  // Apply the rules to the inputs present at the coming clock edge.
  task automatic model_step();
    logic [31:0] nrd;
    bit hit, expire;
    nrd = exp_read(bus.rd_sel);
    if (!rst) begin
      model_clear();
      m_rd = 32'h0;
    end else begin
      m_rd = nrd;
      if (bus.clr) begin
        model_clear();
      end else if (!m_done && !m_to) begin
        hit    = bus.mem_we && (bus.mem_addr == 32'd100);
        expire = !bus.retire_valid && (m_idle == WD - 1);
        m_cyc  = sinc(m_cyc, 1'b1);
        m_ins  = sinc(m_ins, bus.retire_valid);
        m_stl  = sinc(m_stl, bus.stall);
        m_fls  = sinc(m_fls, bus.flush);
        m_idle = bus.retire_valid ? 0 : m_idle + 1;
        if (hit) begin
          m_done  = 1;
          m_res   = bus.mem_wdata;
          m_pass  = (bus.mem_wdata == 32'd25);
          m_since = 0;
          m_cpi   = (m_ins != 0) ? (m_cyc * 100) / m_ins : 0;
        end else if (expire) begin
          m_to = 1;
        end
      end else if (m_done) begin
        m_since++;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("rd_data", bus.rd_data, m_rd);
    check("done", 32'(bus.done), 32'(m_done));
    check("pass", 32'(bus.pass), 32'(m_pass));
    check("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  task automatic idle_in();
    bus.clr = 1'b0; bus.retire_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.mem_we = 1'b0; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_in();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic read(input logic [2:0] sel, output logic [31:0] v);
    idle_in();
    bus.rd_sel = sel;
    step();
    v = bus.rd_data;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    idle_in();
    bus.mem_we = 1'b1; bus.mem_addr = a; bus.mem_wdata = d;
    step();
    idle_in();
  endtask

  task automatic rand_run(input int cycles, input int ret_pct, input int hit_div);
    for (int i = 0; i < cycles; i++) begin
      rst              = ($urandom_range(0, 399) != 0);
      bus.clr          = ($urandom_range(0, 299) == 0);
      bus.retire_valid = ($urandom_range(0, 99) < ret_pct);
      bus.stall        = ($urandom_range(0, 3) == 0);
      bus.flush        = ($urandom_range(0, 4) == 0);
      bus.mem_we       = ($urandom_range(0, 7) == 0);
      bus.mem_addr     = ($urandom_range(0, hit_div) == 0) ? 32'd100 : $urandom;
      bus.mem_wdata    = ($urandom_range(0, 1) == 1) ? 32'd25 : $urandom_range(0, 50);
      bus.rd_sel       = 3'($urandom_range(0, 7));
      step();
    end
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    idle_in();
    bus.rd_sel = 3'd0;
    model_clear();

    // Reset state
    do_reset();
    check("reset_rd", bus.rd_data, 32'h0);
    check("reset_status", {29'b0, bus.timeout, bus.pass, bus.done}, 32'h0);

    // Ten retires then a passing store
    for (int i = 0; i < 10; i++) begin
      idle_in();
      bus.retire_valid = 1'b1;
      step();
    end
    store(32'd100, 32'd25);
    check("pass_done", 32'(bus.done), 32'd1);
    check("pass_pass", 32'(bus.pass), 32'd1);
    read(3'd0, rv); check("pass_sel0", rv, 32'd11);
    read(3'd1, rv); check("pass_sel1", rv, 32'd10);
    read(3'd4, rv); check("pass_sel4", rv, 32'd25);

    // Failing store, then a later store is ignored
    do_reset();
    store(32'd100, 32'd7);
    check("fail_done", 32'(bus.done), 32'd1);
    check("fail_pass", 32'(bus.pass), 32'd0);
    read(3'd4, rv); check("fail_sel4", rv, 32'd7);
    store(32'd100, 32'd25);
    read(3'd4, rv); check("keep_first_sel4", rv, 32'd7);
    check("keep_first_pass", 32'(bus.pass), 32'd0);

    // Watchdog expiry with no retires
    do_reset();
    idle_in();
    n = 0;
    while (!bus.timeout && n < 400) begin
      step();
      n++;
    end
    check("wd_cycles", 32'(n), 32'd256);
    read(3'd0, rv); check("wd_sel0", rv, 32'd256);
    repeat (5) step();
    read(3'd0, rv); check("wd_sel0_frozen", rv, 32'd256);
    read(3'd5, rv); check("wd_status", rv, 32'h4);

    // Done store on the watchdog expiry cycle
    do_reset();
    idle_in();
    repeat (255) step();
    store(32'd100, 32'd25);
    check("coincide_done", 32'(bus.done), 32'd1);
    check("coincide_timeout", 32'(bus.timeout), 32'd0);

    // Stall and flush counts, then clear
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_in(); bus.stall = 1'b1; step();
    end
    for (int i = 0; i < 2; i++) begin
      idle_in(); bus.flush = 1'b1; step();
      idle_in(); step();
    end
    read(3'd2, rv); check("stall_sel2", rv, 32'd3);
    read(3'd3, rv); check("flush_sel3", rv, 32'd2);
    store(32'd100, 32'd25);
    idle_in(); bus.clr = 1'b1; step();
    read(3'd0, rv); check("clr_sel0", rv, 32'd0);
    for (int s = 1; s < 6; s++) begin
      read(3'(s), rv); check("clr_sel", rv, 32'd0);
    end
    check("clr_done", 32'(bus.done), 32'd0);

    // Reset in the middle of activity
    rand_run(40, 60, 50);
    rst = 1'b0; idle_in(); bus.rd_sel = 3'd0; step(); rst = 1'b1;
    check("midrst_rd", bus.rd_data, 32'h0);
    check("midrst_status", {29'b0, bus.timeout, bus.pass, bus.done}, 32'h0);

    // CPI readout: 40 cycles, 20 retires, then done
    do_reset();
    for (int i = 0; i < 39; i++) begin
      idle_in(); bus.retire_valid = (i % 2 == 0); step();
    end
    store(32'd100, 32'd25);
    read(3'd6, rv);
`ifdef PERF_MON_CPI_EN
    check("cpi_pending", rv, 32'hFFFF_FFFF);
    n = 0;
    while (rv == 32'hFFFF_FFFF && n < 100) begin
      read(3'd6, rv);
      n++;
    end
    check("cpi_value", rv, 32'd200);
`else
    check("cpi_disabled", rv, 32'h0);
`endif

    // Randomized traffic
    do_reset();
    rand_run(1500, 70, 20);
    rand_run(1500, 1, 200);
    rand_run(1500, 0, 1000);
    rand_run(1000, 50, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
